// File: rtl/keccak_state_loader_pkg.sv
// Shared types and constants for the Keccak state loader and its lane counter.
// Lane addressing follows the 5x5 state layout: index = 5*y + x.
package keccak_state_loader_pkg;

    localparam int LANE_W    = 64;
    localparam int NUM_LANES = 25;

    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
    } lane_coord;

    typedef logic [1:0] fsm_state;

    localparam fsm_state ST_LOAD = 2'd0;
    localparam fsm_state ST_FIRE = 2'd1;
    localparam fsm_state ST_WAIT = 2'd2;

    function automatic logic [4:0] lane_index(input logic [2:0] x, input logic [2:0] y);
        return 5'(32'(y) * 5 + 32'(x));
    endfunction

endpackage

// File: rtl/lane_coord_counter.sv
// 5x5 lane walker: x runs fastest, y advances on x wrap, idx counts 0..NUM_LANES-1.
// Wraps to the origin after the last lane, so an unloader can reuse it unchanged.
module lane_coord_counter #(
    parameter int NUM_LANES = keccak_state_loader_pkg::NUM_LANES
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear,
    input  logic                              inc,
    output keccak_state_loader_pkg::lane_coord coord,
    output logic [4:0]                        idx,
    output logic                              last
);

    assign last = (idx == 5'(NUM_LANES - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            coord <= '0;
            idx   <= '0;
        end else if (inc) begin
            if (last) begin
                coord <= '0;
                idx   <= '0;
            end else begin
                idx <= idx + 5'd1;
                if (coord.x == 3'd4) begin
                    coord.x <= 3'd0;
                    coord.y <= coord.y + 3'd1;
                end else begin
                    coord.x <= coord.x + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/keccak_state_loader.sv
// Serial lane loader: writes 25 lanes into the shared state memory, pulses start,
// then blocks new input until the round datapath reports core_done.
module keccak_state_loader #(
    parameter int LANE_W     = 64,
    parameter int NUM_LANES  = 25,
    parameter int SWAP_BYTES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [LANE_W-1:0] in_data,
    output logic              in_ready,
    input  logic              core_done,
    output logic              mem_we,
    output logic [4:0]        mem_addr,
    output logic [2:0]        mem_x,
    output logic [2:0]        mem_y,
    output logic [LANE_W-1:0] mem_wdata,
    output logic              start,
    output logic              busy,
    output logic [7:0]        block_cnt,
    output logic [1:0]        state_dbg
);

    import keccak_state_loader_pkg::lane_coord;
    import keccak_state_loader_pkg::fsm_state;
    import keccak_state_loader_pkg::ST_LOAD;
    import keccak_state_loader_pkg::ST_FIRE;
    import keccak_state_loader_pkg::ST_WAIT;
    import keccak_state_loader_pkg::lane_index;

    // Handshake: a lane transfers on a rising edge where in_valid && in_ready.
    // in_ready depends only on state, so upstream never sees a combinational loop.
    fsm_state          state;
    lane_coord         coord;
    logic [4:0]        lane_idx;
    logic              lane_last;
    logic              hs;
    logic [LANE_W-1:0] lane_swapped;

    assign in_ready  = (state == ST_LOAD);
    assign hs        = in_valid && in_ready;
    assign state_dbg = state;

    lane_coord_counter #(.NUM_LANES(NUM_LANES)) u_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (state != ST_LOAD),
        .inc   (hs),
        .coord (coord),
        .idx   (lane_idx),
        .last  (lane_last)
    );

    always_comb begin
        lane_swapped = in_data;
        if (SWAP_BYTES != 0) begin
            for (int b = 0; b < LANE_W / 8; b++) begin
                lane_swapped[8*b +: 8] = in_data[LANE_W-8-8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_x     <= '0;
            mem_y     <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= hs;
            if (hs) begin
                mem_addr  <= lane_index(coord.x, coord.y);
                mem_x     <= coord.x;
                mem_y     <= coord.y;
                mem_wdata <= lane_swapped;
            end
        end
    end

    // start is registered off FIRE so it lands one cycle after the final write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_LOAD;
            start     <= 1'b0;
            busy      <= 1'b0;
            block_cnt <= '0;
        end else begin
            start <= (state == ST_FIRE);
            case (state)
                ST_LOAD: begin
                    if (hs && lane_idx == 5'd0) busy <= 1'b1;
                    if (hs && lane_last) state <= ST_FIRE;
                end
                ST_FIRE: state <= ST_WAIT;
                ST_WAIT: begin
                    if (core_done) begin
                        state     <= ST_LOAD;
                        block_cnt <= block_cnt + 8'd1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_state_loader.sv
// Bench for keccak_state_loader: directed vector table, hand sequences and
// randomized loads checked against a lane-count/timing reference model.
module tb_keccak_state_loader;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         core_done = 1'b0;
    logic [W-1:0] in_data = '0;

    logic         in_ready, mem_we, start, busy;
    logic [4:0]   mem_addr;
    logic [2:0]   mem_x, mem_y;
    logic [W-1:0] mem_wdata;
    logic [7:0]   block_cnt;
    logic [1:0]   state_dbg;

    logic         sw_in_ready, sw_mem_we, sw_start, sw_busy;
    logic [4:0]   sw_mem_addr;
    logic [2:0]   sw_mem_x, sw_mem_y;
    logic [W-1:0] sw_mem_wdata;
    logic [7:0]   sw_block_cnt;
    logic [1:0]   sw_state_dbg;

    keccak_state_loader #(.LANE_W(W), .NUM_LANES(25), .SWAP_BYTES(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .core_done(core_done), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_x(mem_x), .mem_y(mem_y), .mem_wdata(mem_wdata),
        .start(start), .busy(busy), .block_cnt(block_cnt), .state_dbg(state_dbg)
    );

    keccak_state_loader #(.LANE_W(W), .NUM_LANES(25), .SWAP_BYTES(1)) dut_sw (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(sw_in_ready), .core_done(core_done), .mem_we(sw_mem_we),
        .mem_addr(sw_mem_addr), .mem_x(sw_mem_x), .mem_y(sw_mem_y),
        .mem_wdata(sw_mem_wdata), .start(sw_start), .busy(sw_busy),
        .block_cnt(sw_block_cnt), .state_dbg(sw_state_dbg)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [4:0]   addr;
        logic [2:0]   x;
        logic [2:0]   y;
        logic [W-1:0] data;
    } wr_t;

    wr_t  exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   m_known = 0;
    int   m_cnt = 0;      // lanes accepted in the current state
    int   m_after = 0;    // 0 loading, 1 cycle after last lane, 2 waiting for core_done
    bit   exp_ready, exp_we, exp_start, exp_busy;
    int   exp_blk = 0;

    function automatic logic [W-1:0] bswap(input logic [W-1:0] d);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W / 8; i++) r = r | (((d >> (8 * i)) & 64'hff) << (8 * (W / 8 - 1 - i)));
        return r;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        wr_t w;
        if (!m_known) return;
        chk("in_ready", W'(in_ready), W'(exp_ready));
        chk("mem_we", W'(mem_we), W'(exp_we));
        chk("start", W'(start), W'(exp_start));
        chk("busy", W'(busy), W'(exp_busy));
        chk("block_cnt", W'(block_cnt), W'(exp_blk % 256));
        chk("sw_mem_we", W'(sw_mem_we), W'(exp_we));
        chk("sw_start", W'(sw_start), W'(exp_start));
        if (exp_we && exp_q.size() > 0) begin
            w = exp_q.pop_front();
            chk("mem_addr", W'(mem_addr), W'(w.addr));
            chk("mem_x", W'(mem_x), W'(w.x));
            chk("mem_y", W'(mem_y), W'(w.y));
            chk("mem_wdata", mem_wdata, w.data);
            chk("sw_mem_wdata", sw_mem_wdata, bswap(w.data));
        end
    endtask

    task automatic model_update(input bit v, input logic [W-1:0] d, input bit cd, input bit r);
        bit hs;
        if (r) begin
            m_known = 1; m_cnt = 0; m_after = 0; exp_blk = 0;
            exp_ready = 1; exp_we = 0; exp_start = 0; exp_busy = 0;
            exp_q.delete();
            return;
        end
        hs = v && exp_ready;
        exp_we = hs;
        exp_start = 0;
        if (hs) begin
            exp_q.push_back('{addr: 5'(m_cnt), x: 3'(m_cnt % 5), y: 3'(m_cnt / 5), data: d});
            if (m_cnt == 0) exp_busy = 1;
            m_cnt++;
            if (m_cnt == 25) m_after = 1;
        end else if (m_after == 1) begin
            exp_start = 1;
            m_after = 2;
        end else if (m_after == 2 && cd) begin
            m_cnt = 0; m_after = 0; exp_blk = (exp_blk + 1) % 256; exp_busy = 0;
        end
        exp_ready = (m_cnt < 25);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input bit v, input logic [W-1:0] d, input bit cd, input bit r);
        @(negedge clk);
        check_outputs();
        in_valid = v; in_data = d; core_done = cd; rst = r;
        model_update(v, d, cd, r);
    endtask

    function automatic logic [W-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic load_lanes(input int n, input int mode, input bit spur);
        int acc = 0;
        int guard = 0;
        bit v;
        while (acc < n && guard < 2000) begin
            case (mode)
                0: v = 1;
                1: v = guard[0];
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            if (v && exp_ready) acc++;
            step(v, rnd64(), spur && ($urandom_range(0, 9) == 0), 0);
            guard++;
        end
        if (acc < n) begin
            checks++; errors++;
            $display("FAIL load_timeout: got %0d lanes expected %0d", acc, n);
        end
    endtask

    task automatic finish_block(input int wait_cycles, input bit hold_valid);
        int guard = 0;
        while (m_after != 2 && guard < 10) begin
            step(0, '0, 0, 0);
            guard++;
        end
        repeat (wait_cycles) step(hold_valid, rnd64(), 0, 0);
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit           r, v, cd, chk;
        logic [W-1:0] d;
        bit           e_ready, e_we, e_start, e_busy;
        logic [4:0]   e_addr;
        logic [7:0]   e_blk;
    } vec_t;

    vec_t tbl[31];

    initial begin
        int blk0;

        tbl[0] = '{r: 1, v: 0, cd: 0, chk: 0, d: '0, e_ready: 0, e_we: 0, e_start: 0, e_busy: 0, e_addr: 0, e_blk: 0};
        for (int k = 1; k <= 25; k++)
            tbl[k] = '{r: 0, v: 1, cd: 0, chk: 1, d: W'(k - 1), e_ready: 1, e_we: (k >= 2),
                       e_start: 0, e_busy: (k >= 2), e_addr: (k >= 2) ? 5'(k - 2) : 5'd0, e_blk: 0};
        tbl[26] = '{r: 0, v: 1, cd: 0, chk: 1, d: 64'hdead, e_ready: 0, e_we: 1, e_start: 0, e_busy: 1, e_addr: 24, e_blk: 0};
        tbl[27] = '{r: 0, v: 1, cd: 0, chk: 1, d: 64'hdead, e_ready: 0, e_we: 0, e_start: 1, e_busy: 1, e_addr: 24, e_blk: 0};
        tbl[28] = '{r: 0, v: 1, cd: 0, chk: 1, d: 64'hdead, e_ready: 0, e_we: 0, e_start: 0, e_busy: 1, e_addr: 24, e_blk: 0};
        tbl[29] = '{r: 0, v: 0, cd: 1, chk: 1, d: '0, e_ready: 0, e_we: 0, e_start: 0, e_busy: 1, e_addr: 24, e_blk: 0};
        tbl[30] = '{r: 0, v: 0, cd: 0, chk: 1, d: '0, e_ready: 1, e_we: 0, e_start: 0, e_busy: 0, e_addr: 24, e_blk: 1};

        for (int i = 0; i < 31; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].cd, tbl[i].r);
            if (tbl[i].chk) begin
                chk("tbl_ready", W'(in_ready), W'(tbl[i].e_ready));
                chk("tbl_we", W'(mem_we), W'(tbl[i].e_we));
                chk("tbl_addr", W'(mem_addr), W'(tbl[i].e_addr));
                chk("tbl_start", W'(start), W'(tbl[i].e_start));
                chk("tbl_busy", W'(busy), W'(tbl[i].e_busy));
                chk("tbl_blk", W'(block_cnt), W'(tbl[i].e_blk));
            end
        end

        // valid toggling every other cycle
        load_lanes(25, 1, 0);
        finish_block(3, 0);

        // valid held high through a long WAIT
        load_lanes(25, 0, 0);
        finish_block(100, 1);
        chk("blk_after_wait", W'(block_cnt), 64'd3);

        // reset part-way through a load, then a full load
        load_lanes(12, 0, 0);
        step(0, '0, 0, 1);
        load_lanes(25, 0, 0);
        step(0, '0, 0, 0);
        step(0, '0, 0, 0);
        chk("blk_before_done", W'(block_cnt), 64'd0);
        finish_block(2, 0);

        // byte swap of a known lane
        step(1, 64'h0102030405060708, 0, 0);
        step(0, '0, 0, 0);
        chk("swap_const", sw_mem_wdata, 64'h0807060504030201);
        chk("noswap_const", mem_wdata, 64'h0102030405060708);
        load_lanes(24, 0, 0);
        finish_block(1, 0);

        // 256 randomized loads wrap block_cnt back to its starting value
        blk0 = exp_blk;
        for (int n = 0; n < 256; n++) begin
            load_lanes(25, 2, 1);
            finish_block($urandom_range(0, 5), 1'($urandom_range(0, 1)));
        end
        chk("blk_wrap", W'(block_cnt), W'(blk0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
